// File: rtl/mem_arbiter.sv
// Arbitrates one memory port between CPU and DMA: round-robin, DMA burst lock, CPU starvation guard.
// Grant is combinational (0-cycle latency); read rvalid follows 1 cycle later; a loser simply keeps req high.
module mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dma_req,
  input  logic              dma_we,
  input  logic [ADDR_W-1:0] dma_addr,
  input  logic [DATA_W-1:0] dma_wdata,
  input  logic              dma_lock,
  output logic              dma_gnt,
  output logic              dma_rvalid,
  output logic [DATA_W-1:0] dma_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic {ARB, LOCKED} state_e;

  localparam logic [3:0] LOCK_MAX_C = 4'(LOCK_MAX);

  state_e     state_q;
  logic       last_dma_q;
  logic       rd_pend_q;
  logic       rd_dma_q;
  logic [3:0] starve_q;
  logic       force_cpu;

  always_comb begin
    cpu_gnt   = 1'b0;
    dma_gnt   = 1'b0;
    force_cpu = (state_q == LOCKED) && cpu_req && (starve_q == LOCK_MAX_C);
    if (!reset) begin
      if (state_q == ARB) begin
        if (cpu_req && dma_req) begin
          cpu_gnt = last_dma_q;
          dma_gnt = !last_dma_q;
        end else begin
          cpu_gnt = cpu_req;
          dma_gnt = dma_req;
        end
      end else begin
        cpu_gnt = force_cpu;
        dma_gnt = dma_req && !force_cpu;
      end
    end
  end

  always_comb begin
    mem_en    = cpu_gnt | dma_gnt;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (cpu_gnt) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (dma_gnt) begin
      mem_we    = dma_we;
      mem_addr  = dma_addr;
      mem_wdata = dma_wdata;
    end
  end

  // Starvation counter only runs while locked; any exit from LOCKED clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ARB;
      last_dma_q <= 1'b1;
      starve_q   <= 4'd0;
      rd_pend_q  <= 1'b0;
      rd_dma_q   <= 1'b0;
    end else begin
      if (cpu_gnt || dma_gnt) last_dma_q <= dma_gnt;
      rd_pend_q <= (cpu_gnt && !cpu_we) || (dma_gnt && !dma_we);
      rd_dma_q  <= dma_gnt;
      case (state_q)
        ARB: begin
          starve_q <= 4'd0;
          if (dma_gnt && dma_lock) state_q <= LOCKED;
        end
        LOCKED: begin
          if (!dma_lock) begin
            state_q  <= ARB;
            starve_q <= 4'd0;
          end else if (cpu_gnt) begin
            starve_q <= 4'd0;
          end else if (cpu_req && starve_q != 4'hF) begin
            starve_q <= starve_q + 4'd1;
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

  assign cpu_rvalid = rd_pend_q && !rd_dma_q;
  assign dma_rvalid = rd_pend_q && rd_dma_q;
  assign cpu_rdata  = mem_rdata;
  assign dma_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: inputs change 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic        cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
  logic [15:0] dma_addr;
  logic [7:0]  dma_wdata, dma_rdata;
  logic        mem_en, mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(16), .DATA_W(8), .LOCK_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rvalid(dma_rvalid), .dma_rdata(dma_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
  endtask

  task automatic idle;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    dma_req = 0; dma_we = 0; dma_addr = '0; dma_wdata = '0; dma_lock = 0;
  endtask

  initial begin
    idle();
    reset = 1'b1;
    mem_rdata = 8'h00;

    // Reset state
    sample();
    chk("rst_cpu_gnt", cpu_gnt, 0);
    chk("rst_dma_gnt", dma_gnt, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_cpu_rvalid", cpu_rvalid, 0);
    chk("rst_dma_rvalid", dma_rvalid, 0);

    // Lone CPU read
    tick();
    reset = 1'b0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h1234; mem_rdata = 8'hA5;
    sample();
    chk("rd_cpu_gnt", cpu_gnt, 1);
    chk("rd_dma_gnt", dma_gnt, 0);
    chk("rd_mem_en", mem_en, 1);
    chk("rd_mem_addr", mem_addr, 16'h1234);
    chk("rd_mem_we", mem_we, 0);
    tick();
    cpu_req = 0;
    sample();
    chk("rd_cpu_rvalid", cpu_rvalid, 1);
    chk("rd_cpu_rdata", cpu_rdata, 8'hA5);
    chk("rd_dma_rvalid", dma_rvalid, 0);
    chk("rd_idle_mem_en", mem_en, 0);

    // Lone DMA write
    tick();
    dma_req = 1; dma_we = 1; dma_addr = 16'h2000; dma_wdata = 8'h55;
    sample();
    chk("wr_dma_gnt", dma_gnt, 1);
    chk("wr_mem_en", mem_en, 1);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 16'h2000);
    chk("wr_mem_wdata", mem_wdata, 8'h55);
    tick();
    idle();
    sample();
    chk("wr_dma_rvalid", dma_rvalid, 0);
    chk("wr_cpu_rvalid", cpu_rvalid, 0);
    chk("wr_idle_mem_we", mem_we, 0);

    // Contended reads: last grant was DMA so CPU leads, then strict alternation
    for (int i = 0; i < 6; i++) begin
      tick();
      cpu_req = 1; cpu_we = 0; cpu_addr = 16'h0010 + 16'(i);
      dma_req = 1; dma_we = 0; dma_addr = 16'h0020 + 16'(i);
      sample();
      chk($sformatf("rr_cpu_gnt%0d", i), cpu_gnt, (i % 2 == 0) ? 1 : 0);
      chk($sformatf("rr_dma_gnt%0d", i), dma_gnt, (i % 2 == 1) ? 1 : 0);
      chk($sformatf("rr_addr%0d", i), mem_addr,
          (i % 2 == 0) ? 16'h0010 + 16'(i) : 16'h0020 + 16'(i));
      if (i > 0) begin
        chk($sformatf("rr_cpu_rv%0d", i), cpu_rvalid, ((i - 1) % 2 == 0) ? 1 : 0);
        chk($sformatf("rr_dma_rv%0d", i), dma_rvalid, ((i - 1) % 2 == 1) ? 1 : 0);
      end
    end
    tick();
    idle();
    sample();
    chk("rr_last_dma_rv", dma_rvalid, 1);
    chk("rr_last_cpu_rv", cpu_rvalid, 0);

    // DMA locked burst with a waiting CPU: forced CPU slot after 4 blocked cycles
    tick();
    dma_req = 1; dma_we = 1; dma_lock = 1; dma_addr = 16'h0100; dma_wdata = 8'h00;
    sample();
    chk("lk_enter_dma_gnt", dma_gnt, 1);
    tick();
    dma_addr = 16'h0101; dma_wdata = 8'h01;
    cpu_req = 1; cpu_we = 1; cpu_addr = 16'h3000; cpu_wdata = 8'hC3;
    for (int k = 0; k < 4; k++) begin
      sample();
      chk($sformatf("lk_dma_gnt%0d", k), dma_gnt, 1);
      chk($sformatf("lk_cpu_gnt%0d", k), cpu_gnt, 0);
      chk($sformatf("lk_addr%0d", k), mem_addr, 16'h0101 + 16'(k));
      tick();
      dma_addr = 16'h0102 + 16'(k); dma_wdata = 8'h02 + 8'(k);
    end
    sample();
    chk("lk_force_cpu_gnt", cpu_gnt, 1);
    chk("lk_force_dma_gnt", dma_gnt, 0);
    chk("lk_force_addr", mem_addr, 16'h3000);
    chk("lk_force_wdata", mem_wdata, 8'hC3);
    tick();
    cpu_req = 0;
    sample();
    chk("lk_resume_dma_gnt", dma_gnt, 1);
    chk("lk_resume_addr", mem_addr, 16'h0105);
    tick();
    dma_addr = 16'h0106;
    sample();
    chk("lk_persist_dma_gnt", dma_gnt, 1);

    // Lock release with CPU waiting: DMA keeps this cycle, CPU wins the next
    tick();
    dma_addr = 16'h0107; dma_lock = 0; cpu_req = 1;
    sample();
    chk("rel_dma_gnt", dma_gnt, 1);
    chk("rel_cpu_gnt", cpu_gnt, 0);
    tick();
    sample();
    chk("rel_next_cpu_gnt", cpu_gnt, 1);
    chk("rel_next_dma_gnt", dma_gnt, 0);

    // Reset right after a granted CPU read drops the response
    tick();
    idle();
    cpu_req = 1; cpu_we = 0; cpu_addr = 16'h4444;
    sample();
    chk("rr_pre_cpu_gnt", cpu_gnt, 1);
    tick();
    reset = 1'b1;
    idle();
    sample();
    chk("mrst_cpu_rvalid", cpu_rvalid, 0);
    chk("mrst_dma_rvalid", dma_rvalid, 0);
    chk("mrst_mem_en", mem_en, 0);
    tick();
    tick();
    reset = 1'b0;
    sample();
    chk("post_rst_cpu_rvalid", cpu_rvalid, 0);
    tick();
    cpu_req = 1; dma_req = 1;
    sample();
    chk("post_rst_tie_cpu", cpu_gnt, 1);
    chk("post_rst_tie_dma", dma_gnt, 0);
    tick();
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares the single synchronous memory port between the CPU control sequencer and a DMA requester (program loader / peripheral copy engine). Grants at most one access per cycle: round-robin fairness, a DMA bus lock for bursts, and a starvation guard that forces CPU slots during long locks. It sits between the CPU memory-control outputs and the memory, and steers read data back to the requester that issued the read.

## Interface
- ADDR_W, 16, address width (matches the 16-bit memory pointer)
- DATA_W, 8, data width
- LOCK_MAX, 4, consecutive cycles a waiting CPU may be blocked by a DMA lock before it is forced a slot; legal range 1..15

Clock and reset: one clock; reset is asynchronous and active-high.
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- cpu_req  input  1  CPU access request, held until granted
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  ADDR_W  CPU address
- cpu_wdata  input  DATA_W  CPU write data
- cpu_gnt  output  1  CPU access performed this cycle
- cpu_rvalid  output  1  cpu_rdata valid (read response)
- cpu_rdata  output  DATA_W  read data to CPU
- dma_req, dma_we, dma_addr, dma_wdata  input  1/1/ADDR_W/DATA_W  DMA request, same semantics as CPU
- dma_lock  input  1  DMA requests exclusive ownership after its current grant
- dma_gnt, dma_rvalid, dma_rdata  output  1/1/DATA_W  as CPU
- mem_en  output  1  memory access strobe
- mem_we  output  1  write strobe
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid the cycle after a read strobe

## Operation
- Handshake: req is a level; a transfer occurs in every cycle where req && gnt. Requester keeps req/we/addr/wdata stable until gnt; holding req high after gnt requests another transfer.
- States: ARB, LOCKED. Registers: last_gnt (CPU/DMA), starve_cnt (4 bits), rd_pend, rd_owner.
- ARB grant: only one req -> that one; both -> requester not in last_gnt. last_gnt updates on every grant.
- ARB -> LOCKED when a DMA grant occurs with dma_lock=1.
- LOCKED grant: DMA only, unless starve_cnt == LOCK_MAX and cpu_req, then CPU (one transfer), starve_cnt cleared. starve_cnt increments each LOCKED cycle with cpu_req && !cpu_gnt; clears on CPU grant or leaving LOCKED.
- LOCKED -> ARB at any edge where dma_lock=0 (whether or not DMA transfers); dma_req may drop while locked without releasing.
- mem_en = cpu_gnt | dma_gnt; mem_we/addr/wdata muxed from granted requester; with no grant mem_we=0, mem_addr=0, mem_wdata=0.
- Read response: at a granted read edge set rd_pend=1, rd_owner=grantee; next cycle assert owner's rvalid. cpu_rdata and dma_rdata both equal mem_rdata continuously; only rvalid is steered. Writes produce no rvalid.
- Reset: state ARB, last_gnt=DMA (CPU wins first tie), starve_cnt=0, rd_pend=0; all outputs 0. Reset mid-read drops the response (no rvalid after reset release).

## Timing
- gnt and mem_* combinational from req and registered state: zero-cycle grant latency when uncontended.
- Read data latency: rvalid exactly 1 cycle after gnt; back-to-back reads give rvalid every cycle, in grant order.
- Contended tie (ARB): at most 1 cycle wait per requester.
- Locked worst-case CPU wait: LOCK_MAX cycles, granted on cycle LOCK_MAX+1.
- Lock release cycle (dma_lock=0 while LOCKED): DMA still has sole access that cycle; from next cycle ARB, last_gnt=DMA, so a waiting CPU wins.

## Test plan
- Reset, then cpu_req read addr 0x1234 alone -> cpu_gnt=1 same cycle, mem_addr=0x1234, mem_we=0; next cycle cpu_rvalid=1, cpu_rdata=mem_rdata (0xA5), dma_rvalid=0.
- Both req every cycle, no lock, 6 cycles -> grants CPU,DMA,CPU,DMA,CPU,DMA; rvalids follow one cycle later in same order.
- DMA write 0x0100..0x0107 with dma_lock=1, cpu_req held, LOCK_MAX=4 -> DMA grants 4 cycles, CPU granted cycle 5, DMA resumes; lock persists.
- dma_lock dropped while LOCKED with cpu_req high -> DMA granted that cycle, CPU next cycle.
- Assert reset the cycle after a granted CPU read -> no cpu_rvalid, all outputs 0, first post-reset tie goes to CPU.
- DMA write 0x55 to 0x2000 -> mem_en=1, mem_we=1, mem_wdata=0x55 same cycle; no dma_rvalid.
